// File: rtl/execute_iter.sv
// execute_iter: execute stage for the pipelined core.
// Resolves EX/MEM and MEM/WB forwarding when an operation is accepted.
// ALU, set and branch operations finish in one cycle. The result goes to
// the memory stage through a registered valid/ready output.
// Optional feature macro: EXECUTE_ITER_MUL_EN adds an iterative shift-add
// multiplier. While it runs, the front end is stalled through in_ready.
// Without the macro, MUL completes in one cycle with result 0 and err set.
//
// state  | meaning
// S_IDLE | accepting operations; single-cycle ops load the output register
// S_BUSY | multiply in progress, one shift-add step per cycle
module execute_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             branch,
  input  logic [1:0]       cond,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] pc_inc,
  input  logic             fwd_exmem_a,
  input  logic             fwd_exmem_b,
  input  logic             fwd_memwb_a,
  input  logic             fwd_memwb_b,
  input  logic [WIDTH-1:0] exmem_data,
  input  logic [WIDTH-1:0] memwb_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] st_value,
  output logic             take_branch,
  output logic [WIDTH-1:0] next_pc,
  output logic             err
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SEQ = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SCO = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] st_value_q;
  logic [WIDTH-1:0] next_pc_q;
  logic             take_branch_q;
  logic             err_q;

  logic [WIDTH-1:0] opa_d;
  logic [WIDTH-1:0] rt_fwd_d;
  logic [WIDTH-1:0] opb_d;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] npc_d;
  logic             taken_d;
  logic             err_d;
  logic             mul_start;
  logic             accept;

`ifdef EXECUTE_ITER_MUL_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] prod_q;
  logic [WIDTH-1:0] pend_st_q;
  logic [WIDTH-1:0] pend_pc_q;
  logic [WIDTH-1:0] prod_step_d;

  // Partial product after this cycle's shift-add step; only low WIDTH bits matter.
  always_comb begin
    prod_step_d = prod_q + (mplier_q[0] ? mcand_q : '0);
  end
`endif

  assign in_ready = ~rst & ~flush & (state_q == S_IDLE) & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // Operand forwarding: EX/MEM has priority over MEM/WB.
  always_comb begin
    opa_d = rs_data;
    if (fwd_exmem_a)      opa_d = exmem_data;
    else if (fwd_memwb_a) opa_d = memwb_data;
    rt_fwd_d = rt_data;
    if (fwd_exmem_b)      rt_fwd_d = exmem_data;
    else if (fwd_memwb_b) rt_fwd_d = memwb_data;
    opb_d = use_imm ? imm : rt_fwd_d;
  end

  // Single-cycle result, branch resolution and illegal-op detection.
  always_comb begin
    sum_d     = {1'b0, opa_d} + {1'b0, opb_d};
    res_d     = '0;
    taken_d   = 1'b0;
    err_d     = 1'b0;
    mul_start = 1'b0;
    if (branch) begin
      case (cond)
        2'b00:   taken_d = (opa_d == '0);
        2'b01:   taken_d = (opa_d != '0);
        2'b10:   taken_d = opa_d[WIDTH-1];
        default: taken_d = ~opa_d[WIDTH-1];
      endcase
    end else begin
      case (op)
        OP_ADD:  res_d = sum_d[WIDTH-1:0];
        OP_SUB:  res_d = opa_d - opb_d;
        OP_AND:  res_d = opa_d & opb_d;
        OP_XOR:  res_d = opa_d ^ opb_d;
        OP_SEQ:  res_d = {{(WIDTH-1){1'b0}}, (opa_d == opb_d)};
        OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(opa_d) < $signed(opb_d))};
        OP_SCO:  res_d = {{(WIDTH-1){1'b0}}, sum_d[WIDTH]};
        default: begin
`ifdef EXECUTE_ITER_MUL_EN
          mul_start = 1'b1;
`else
          err_d = 1'b1;
`endif
        end
      endcase
    end
    npc_d = taken_d ? (pc_inc + imm) : pc_inc;
  end

  // Control FSM and output register; flush aborts, reset also clears outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      out_valid_q   <= 1'b0;
      result_q      <= '0;
      st_value_q    <= '0;
      next_pc_q     <= '0;
      take_branch_q <= 1'b0;
      err_q         <= 1'b0;
`ifdef EXECUTE_ITER_MUL_EN
      cnt_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      prod_q        <= '0;
      pend_st_q     <= '0;
      pend_pc_q     <= '0;
`endif
    end else if (flush) begin
      state_q       <= S_IDLE;
      out_valid_q   <= 1'b0;
      take_branch_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept && mul_start) begin
`ifdef EXECUTE_ITER_MUL_EN
            state_q   <= S_BUSY;
            cnt_q     <= '0;
            mcand_q   <= opa_d;
            mplier_q  <= opb_d;
            prod_q    <= '0;
            pend_st_q <= rt_fwd_d;
            pend_pc_q <= pc_inc;
`endif
          end else if (accept) begin
            out_valid_q   <= 1'b1;
            result_q      <= res_d;
            st_value_q    <= rt_fwd_d;
            next_pc_q     <= npc_d;
            take_branch_q <= taken_d;
            err_q         <= err_d;
          end
        end
        default: begin
`ifdef EXECUTE_ITER_MUL_EN
          prod_q   <= prod_step_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q       <= S_IDLE;
            out_valid_q   <= 1'b1;
            result_q      <= prod_step_d;
            st_value_q    <= pend_st_q;
            next_pc_q     <= pend_pc_q;
            take_branch_q <= 1'b0;
            err_q         <= 1'b0;
          end
`else
          state_q <= S_IDLE;
`endif
        end
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign st_value    = st_value_q;
  assign next_pc     = next_pc_q;
  assign take_branch = take_branch_q;
  assign err         = err_q;

endmodule

// File: tb/tb_execute_iter.sv
// Testbench for execute_iter: table-driven vectors through a scoreboard,
// plus hand-written back-pressure, flush, reset and multiply sequences.
`timescale 1ns/1ps
module tb_execute_iter;
  localparam int W = 16;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SEQ = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SCO = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, branch, use_imm, flush, out_valid, out_ready;
  logic take_branch, err;
  logic [2:0] op;
  logic [1:0] cond;
  logic fwd_exmem_a, fwd_exmem_b, fwd_memwb_a, fwd_memwb_b;
  logic [W-1:0] rs_data, rt_data, imm, pc_inc, exmem_data, memwb_data;
  logic [W-1:0] result, st_value, next_pc;

  execute_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .branch(branch), .cond(cond), .use_imm(use_imm),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .pc_inc(pc_inc),
    .fwd_exmem_a(fwd_exmem_a), .fwd_exmem_b(fwd_exmem_b),
    .fwd_memwb_a(fwd_memwb_a), .fwd_memwb_b(fwd_memwb_b),
    .exmem_data(exmem_data), .memwb_data(memwb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .st_value(st_value), .take_branch(take_branch), .next_pc(next_pc), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [2:0]   op;
    logic         br;
    logic [1:0]   cond;
    logic         ui;
    logic [W-1:0] rs, rt, imm, pc;
    logic [1:0]   fa, fb;   // {exmem, memwb} select bits
    logic [W-1:0] exm, mwb;
    logic [W-1:0] e_res, e_st;
    logic         e_tb;
    logic [W-1:0] e_npc;
    logic         e_err;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] st;
    logic [W-1:0] npc;
    logic         tb;
    logic         err;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mkv(input logic [2:0] o, input logic br, input logic [1:0] c,
                               input logic ui, input logic [W-1:0] rs, input logic [W-1:0] rt,
                               input logic [W-1:0] im, input logic [W-1:0] pc,
                               input logic [1:0] fa, input logic [1:0] fb,
                               input logic [W-1:0] exm, input logic [W-1:0] mwb,
                               input logic [W-1:0] e_res, input logic [W-1:0] e_st,
                               input logic e_tb, input logic [W-1:0] e_npc, input logic e_err);
    vec_t v;
    v.op = o; v.br = br; v.cond = c; v.ui = ui; v.rs = rs; v.rt = rt; v.imm = im; v.pc = pc;
    v.fa = fa; v.fb = fb; v.exm = exm; v.mwb = mwb;
    v.e_res = e_res; v.e_st = e_st; v.e_tb = e_tb; v.e_npc = e_npc; v.e_err = e_err;
    return v;
  endfunction

  function automatic exp_t exp_of(input vec_t v);
    exp_t e;
    e.res = v.e_res; e.st = v.e_st; e.npc = v.e_npc; e.tb = v.e_tb; e.err = v.e_err;
    return e;
  endfunction

  function automatic logic [W-1:0] ref_alu(input logic [2:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] r;
    case (o)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a + (~b) + 16'h0001;
      OP_AND:  r = a & b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  task automatic drive(input vec_t v);
    op = v.op; branch = v.br; cond = v.cond; use_imm = v.ui;
    rs_data = v.rs; rt_data = v.rt; imm = v.imm; pc_inc = v.pc;
    fwd_exmem_a = v.fa[1]; fwd_memwb_a = v.fa[0];
    fwd_exmem_b = v.fb[1]; fwd_memwb_b = v.fb[0];
    exmem_data = v.exm; memwb_data = v.mwb;
  endtask

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Offer one operation, wait (bounded) for acceptance, record its expected result.
  task automatic send(input vec_t v);
    int tries;
    bit ok;
    tries = 0;
    ok = 1'b0;
    drive(v);
    in_valid = 1'b1;
    while (!ok && tries < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else tries++;
    end
    if (ok) sb_q.push_back(exp_of(v));
    else begin
      checks++;
      errors++;
      $display("FAIL send_timeout op %0d not accepted within 200 cycles", v.op);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every result handed to the memory stage is checked against the scoreboard.
  initial begin : monitor
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        got = {result, st_value, next_pc, take_branch, err};
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected result %h st %h npc %h tb %b err %b", result, st_value,
                   next_pc, take_branch, err);
        end else begin
          e = sb_q.pop_front();
          if (got !== e)
            begin
              errors++;
              $display("FAIL sb_result got res %h st %h npc %h tb %b err %b expected res %h st %h npc %h tb %b err %b",
                       result, st_value, next_pc, take_branch, err, e.res, e.st, e.npc, e.tb, e.err);
            end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t v, va, vb;
    int t0, lows, bad;
    logic [2:0] rop;
    logic [W-1:0] ra, rb, rm;
    logic rui;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    v = mkv(OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(v);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_st_value", st_value, 0);
    chk("rst_next_pc", next_pc, 0);
    chk("rst_take_branch", take_branch, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready_low", in_ready, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Vector table: op br cond ui rs rt imm pc fa fb exm mwb | res st tb npc err
    vecs.push_back(mkv(OP_ADD, 0, 2'b00, 0, 16'hAAAA, 16'h0003, 16'h0000, 16'h0100, 2'b11, 2'b00, 16'h0010, 16'h0020, 16'h0013, 16'h0003, 0, 16'h0100, 0));
    vecs.push_back(mkv(OP_SLT, 0, 2'b00, 0, 16'h8000, 16'h0001, 16'h0000, 16'h0100, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 0, 16'h0100, 0));
    vecs.push_back(mkv(OP_SCO, 0, 2'b00, 0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0100, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 0, 16'h0100, 0));
    vecs.push_back(mkv(OP_ADD, 1, 2'b10, 0, 16'hFFFE, 16'h5555, 16'hFFF0, 16'h0100, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h5555, 1, 16'h00F0, 0));
    vecs.push_back(mkv(OP_ADD, 1, 2'b11, 0, 16'hFFFE, 16'h5555, 16'hFFF0, 16'h0100, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h5555, 0, 16'h0100, 0));
    vecs.push_back(mkv(OP_SUB, 0, 2'b00, 0, 16'h0005, 16'h0007, 16'h0000, 16'h0102, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'hFFFE, 16'h0007, 0, 16'h0102, 0));
    vecs.push_back(mkv(OP_AND, 0, 2'b00, 1, 16'hF0F0, 16'h1234, 16'h0FF0, 16'h0104, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h00F0, 16'h1234, 0, 16'h0104, 0));
    vecs.push_back(mkv(OP_XOR, 0, 2'b00, 0, 16'h0F0F, 16'h9999, 16'h0000, 16'h0106, 2'b00, 2'b01, 16'hDEAD, 16'h00FF, 16'h0FF0, 16'h00FF, 0, 16'h0106, 0));
    vecs.push_back(mkv(OP_SEQ, 0, 2'b00, 0, 16'h1234, 16'h1234, 16'h0000, 16'h0108, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0001, 16'h1234, 0, 16'h0108, 0));
    vecs.push_back(mkv(OP_SEQ, 0, 2'b00, 0, 16'h1234, 16'h1235, 16'h0000, 16'h010A, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h1235, 0, 16'h010A, 0));
    vecs.push_back(mkv(OP_SLT, 0, 2'b00, 0, 16'h0001, 16'h8000, 16'h0000, 16'h010C, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 0, 16'h010C, 0));
    vecs.push_back(mkv(OP_SLT, 0, 2'b00, 0, 16'hFFFF, 16'h0001, 16'h0000, 16'h010C, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 0, 16'h010C, 0));
    vecs.push_back(mkv(OP_SCO, 0, 2'b00, 0, 16'h8000, 16'h7FFF, 16'h0000, 16'h010E, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 0, 16'h010E, 0));
    vecs.push_back(mkv(OP_ADD, 0, 2'b00, 0, 16'hFFFF, 16'h0002, 16'h0000, 16'h0110, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0001, 16'h0002, 0, 16'h0110, 0));
    vecs.push_back(mkv(OP_ADD, 1, 2'b00, 0, 16'h1111, 16'h0000, 16'h0010, 16'h0200, 2'b10, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0210, 0));
    vecs.push_back(mkv(OP_ADD, 1, 2'b01, 0, 16'h0000, 16'h0000, 16'h0010, 16'h0200, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0200, 0));
    vecs.push_back(mkv(OP_ADD, 0, 2'b00, 0, 16'h0001, 16'h0300, 16'h0000, 16'h0112, 2'b00, 2'b11, 16'h0100, 16'h0200, 16'h0101, 16'h0100, 0, 16'h0112, 0));
    vecs.push_back(mkv(OP_ADD, 0, 2'b00, 1, 16'h0010, 16'h4444, 16'hFFFF, 16'h0114, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h000F, 16'h4444, 0, 16'h0114, 0));
    vecs.push_back(mkv(OP_ADD, 1, 2'b11, 0, 16'h0001, 16'h0000, 16'h0004, 16'hFFFE, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0002, 0));
    vecs.push_back(mkv(OP_SUB, 0, 2'b00, 0, 16'h9999, 16'h0010, 16'h0000, 16'h0116, 2'b01, 2'b00, 16'h0000, 16'h0050, 16'h0040, 16'h0010, 0, 16'h0116, 0));
`ifndef EXECUTE_ITER_MUL_EN
    vecs.push_back(mkv(OP_MUL, 0, 2'b00, 0, 16'h0007, 16'h0009, 16'h0000, 16'h0300, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0009, 0, 16'h0300, 1));
`endif
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rm  = 16'($urandom);
      rui = 1'($urandom_range(0, 1));
      vecs.push_back(mkv(rop, 0, 2'b00, rui, ra, rb, rm, 16'h0400, 2'b00, 2'b00, 16'h0000, 16'h0000,
                         ref_alu(rop, ra, rui ? rm : rb), rb, 0, 16'h0400, 0));
    end

    // Stream all vectors back to back with out_ready high: one accept per cycle.
    @(posedge clk); #1;
    t0 = cyc;
    foreach (vecs[i]) send(vecs[i]);
    chk("throughput_cycles", 16'(cyc - t0), 16'(vecs.size()));
    repeat (2) @(posedge clk);
    #1;
    chk("stream_drained", 16'(sb_q.size()), 0);

    // Back-pressure: first result holds, in_ready low, then one result per cycle.
    va = mkv(OP_ADD, 0, 2'b00, 0, 16'h0001, 16'h0002, 16'h0000, 16'h0040, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0003, 16'h0002, 0, 16'h0040, 0);
    vb = mkv(OP_ADD, 0, 2'b00, 0, 16'h0005, 16'h0006, 16'h0000, 16'h0042, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h000B, 16'h0006, 0, 16'h0042, 0);
    out_ready = 1'b0;
    send(va);
    drive(vb);
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) chk("bp_latency_valid", out_valid, 1);
      if (in_ready !== 1'b0) bad++;
      if (out_valid !== 1'b1 || result !== 16'h0003 || st_value !== 16'h0002) bad++;
    end
    chk("bp_hold_and_stall", 16'(bad), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    sb_q.push_back(exp_of(vb));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", out_valid, 1);
    @(posedge clk); #1;

    // Flush kills a held branch result and blocks acceptance.
    out_ready = 1'b0;
    send(vecs[3]);
    drive(va);
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_blocks_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_in_ready_2", in_ready, 0);
    chk("flush_clr_valid", out_valid, 0);
    chk("flush_clr_tb", take_branch, 0);
    chk("flush_clr_err", err, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("flush_no_accept", out_valid, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;

`ifdef EXECUTE_ITER_MUL_EN
    // MUL 7 x 9: WIDTH stall cycles, result one cycle later.
    v = mkv(OP_MUL, 0, 2'b00, 0, 16'h0007, 16'h0009, 16'h0000, 16'h0300, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h003F, 16'h0009, 0, 16'h0300, 0);
    send(v);
    lows = 0; bad = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (!in_ready) lows++;
      if (out_valid) bad++;
    end
    chk("mul_stall_cycles", 16'(lows), 16'(W));
    chk("mul_no_early_valid", 16'(bad), 0);
    @(negedge clk);
    chk("mul_valid_at_n17", out_valid, 1);
    @(posedge clk); #1;

    // MUL 0x1234 x 0x0100 with immediate operand.
    v = mkv(OP_MUL, 0, 2'b00, 1, 16'h1234, 16'h7777, 16'h0100, 16'h0302, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h3400, 16'h7777, 0, 16'h0302, 0);
    send(v);
    repeat (W + 2) @(posedge clk);
    #1;
    chk("mul2_drained", 16'(sb_q.size()), 0);

    // Flush at N+5 aborts the multiply.
    send(v);
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("mul_flush_in_ready", in_ready, 1);
    bad = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("mul_flush_no_result", 16'(bad), 0);
    @(posedge clk); #1;

    // Reset at N+5 of a multiply zeroes all outputs.
    send(v);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
`else
    // Reset while a result is held zeroes all outputs.
    out_ready = 1'b0;
    send(va);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    sb_q.delete();
`endif
    @(negedge clk);
    chk("rstmid_in_ready", in_ready, 1);
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_result", result, 0);
    chk("rstmid_st", st_value, 0);
    chk("rstmid_npc", next_pc, 0);
    chk("rstmid_tb", take_branch, 0);
    chk("rstmid_err", err, 0);
    bad = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("rstmid_no_result", 16'(bad), 0);
    @(posedge clk); #1;

    // Recovery after reset.
    send(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("final_drained", 16'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
